// File: rtl/ro_sampler_pkg.sv
// Shared FSM encoding and counter-width helper for the ring-oscillator sampler.
package ro_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Bits needed for a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_sampler_if.sv
// Control, oscillator and output-word signals of the ring-oscillator sampler.
interface ro_sampler_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       fb_sel;
    logic             ro_in;
    logic             ro_enable;
    logic [1:0]       ro_fb_idx;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             health_fail;
    logic             overrun;
    logic             clr_status;

    modport master (
        output en, fb_sel, ro_in, ready, clr_status,
        input  ro_enable, ro_fb_idx, data, valid, health_fail, overrun
    );

    modport slave (
        input  en, fb_sel, ro_in, ready, clr_status,
        output ro_enable, ro_fb_idx, data, valid, health_fail, overrun
    );
endinterface

// File: rtl/ro_sampler_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clk. Backpressure: none.
// Reset clears both stages so the first synchronised value after reset is 0.
module ro_sampler_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/ro_sampler.sv
// Ring-oscillator consumer: warm-up, divided sampling, repetition-count test, optional von Neumann, word packing.
// Latency: ro_in seen by the sampler 2 clk later; a finished word is offered 1 clk after its last bit.
// Backpressure: data held while valid&&!ready; a word finishing then is dropped and sets sticky overrun.
module ro_sampler
    import ro_sampler_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_DIV    = 16,
    parameter int WARMUP_CYCLES = 64,
    parameter int RCT_LIMIT     = 32,
    parameter int VN_EN         = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    ro_sampler_if.slave io_bus
);
    localparam int DIV_W  = cnt_w(SAMPLE_DIV);
    localparam int WARM_W = cnt_w(WARMUP_CYCLES);
    localparam int BCNT_W = cnt_w(WIDTH);
    localparam int RCT_W  = $clog2(RCT_LIMIT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
    localparam logic [RCT_W-1:0]  RCT_MAX   = RCT_W'(RCT_LIMIT);

    state_t             r_state, w_next_state;
    logic [WARM_W-1:0]  r_warm;
    logic [DIV_W-1:0]   r_div;
    logic [RCT_W-1:0]   r_rct, w_rct_next;
    logic               r_prev;
    logic               r_vn_have, r_vn_first;
    logic [WIDTH-2:0]   r_shift;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [WIDTH-1:0]   r_data, w_word;
    logic               r_valid, r_health_fail, r_overrun, r_ro_enable;
    logic [1:0]         r_fb_idx;
    logic               w_ro_s, w_strobe, w_same, w_trip, w_feed;
    logic               w_bit_vld, w_bit, w_done, w_accept;

    ro_sampler_sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (io_bus.ro_in),
        .o_q     (w_ro_s)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (io_bus.en) w_next_state = ST_WARMUP;
            ST_WARMUP: begin
                if (!io_bus.en)               w_next_state = ST_IDLE;
                else if (r_warm == WARM_LAST) w_next_state = ST_RUN;
            end
            ST_RUN:    if (!io_bus.en) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // The sample that trips the health test is rejected along with everything after it.
    always_comb begin
        w_strobe   = (r_state == ST_RUN) && io_bus.en && (r_div == DIV_LAST);
        w_same     = (r_rct != '0) && (w_ro_s == r_prev);
        w_rct_next = RCT_W'(1);
        if (w_same) w_rct_next = (r_rct == RCT_MAX) ? r_rct : r_rct + 1'b1;
        w_trip     = w_strobe && (w_rct_next == RCT_MAX);
        w_feed     = w_strobe && !r_health_fail && !w_trip;
        w_bit_vld  = w_feed;
        w_bit      = w_ro_s;
        if (VN_EN != 0) begin
            w_bit_vld = w_feed && r_vn_have && (r_vn_first != w_ro_s);
            w_bit     = r_vn_first;
        end
        w_word   = {r_shift, w_bit};
        w_done   = w_bit_vld && (r_bcnt == BCNT_LAST);
        w_accept = !r_valid || io_bus.ready;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_warm        <= '0;
            r_div         <= '0;
            r_rct         <= '0;
            r_prev        <= 1'b0;
            r_vn_have     <= 1'b0;
            r_vn_first    <= 1'b0;
            r_shift       <= '0;
            r_bcnt        <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_health_fail <= 1'b0;
            r_overrun     <= 1'b0;
            r_ro_enable   <= 1'b0;
            r_fb_idx      <= 2'b00;
        end else begin
            r_state     <= w_next_state;
            r_ro_enable <= (w_next_state != ST_IDLE);
            r_fb_idx    <= io_bus.fb_sel;
            r_warm      <= (r_state == ST_WARMUP && w_next_state == ST_WARMUP) ? r_warm + 1'b1 : '0;
            if (r_state == ST_RUN && w_next_state == ST_RUN)
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            else
                r_div <= '0;

            if (w_strobe) begin
                r_prev <= w_ro_s;
                r_rct  <= w_rct_next;
            end else if (io_bus.clr_status) begin
                r_rct  <= '0;
            end
            if (w_trip)                 r_health_fail <= 1'b1;
            else if (io_bus.clr_status) r_health_fail <= 1'b0;

            // Leaving the run state forgets any half-built word and unpaired sample.
            if (!io_bus.en) begin
                r_bcnt    <= '0;
                r_shift   <= '0;
                r_vn_have <= 1'b0;
            end else begin
                if (w_feed) begin
                    r_vn_have <= !r_vn_have;
                    if (!r_vn_have) r_vn_first <= w_ro_s;
                end
                if (w_bit_vld) begin
                    if (w_done) begin
                        r_bcnt <= '0;
                    end else begin
                        r_bcnt  <= r_bcnt + 1'b1;
                        r_shift <= w_word[WIDTH-2:0];
                    end
                end
            end

            if (w_done && w_accept) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && io_bus.ready) begin
                r_valid <= 1'b0;
            end
            if (w_done && !w_accept)    r_overrun <= 1'b1;
            else if (io_bus.clr_status) r_overrun <= 1'b0;
        end
    end

    assign io_bus.ro_enable   = r_ro_enable;
    assign io_bus.ro_fb_idx   = r_fb_idx;
    assign io_bus.data        = r_data;
    assign io_bus.valid       = r_valid;
    assign io_bus.health_fail = r_health_fail;
    assign io_bus.overrun     = r_overrun;
endmodule

// File: tb/tb_ro_sampler.sv
// Bench: raw (VN off) and debiased (VN on) samplers share stimulus; both are checked every cycle
// against an arithmetic reference model, plus literal expectations for the directed scenarios.
module tb_ro_sampler;
    localparam int W    = 8;
    localparam int DIV  = 4;
    localparam int WARM = 8;
    localparam int LIM  = 32;

    logic       clk = 1'b0;
    logic       rst_n, en, ready, clr, ro_in;
    logic [1:0] fb_sel;

    always #5 clk = ~clk;

    ro_sampler_if #(.WIDTH(W)) bus0 ();
    ro_sampler_if #(.WIDTH(W)) bus1 ();

    assign bus0.en = en;       assign bus1.en = en;
    assign bus0.fb_sel = fb_sel; assign bus1.fb_sel = fb_sel;
    assign bus0.ro_in = ro_in; assign bus1.ro_in = ro_in;
    assign bus0.ready = ready; assign bus1.ready = ready;
    assign bus0.clr_status = clr; assign bus1.clr_status = clr;

    ro_sampler #(.WIDTH(W), .SAMPLE_DIV(DIV), .WARMUP_CYCLES(WARM), .RCT_LIMIT(LIM), .VN_EN(0))
        u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus0));
    ro_sampler #(.WIDTH(W), .SAMPLE_DIV(DIV), .WARMUP_CYCLES(WARM), .RCT_LIMIT(LIM), .VN_EN(1))
        u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1));

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;
    logic [7:0] cap0[$];
    logic [7:0] cap1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] qat0(input int i);
        if (i < cap0.size()) return 32'(cap0[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qat1(input int i);
        if (i < cap1.size()) return 32'(cap1[i]);
        return 32'hFFFF_FFFF;
    endfunction

    // Reference model: index 0 = raw bits, index 1 = von Neumann pairs.
    int         m_n;          // consecutive clocks with en high
    bit         m_h1, m_h2;   // ro_in one and two clocks back
    bit         m_roen;
    logic [1:0] m_fb;
    bit         m_vld[2];
    logic [7:0] m_dat[2];
    bit         m_hf[2], m_ov[2];
    int         m_run[2];
    bit         m_last[2], m_ph[2], m_pa[2];
    int         m_nb[2], m_acc[2];
    bit         m_s, m_strobe;

    task automatic model_dut(input int d, input bit s, input bit strobe);
        bit hf_old, trip, got, b, done, busy;
        logic [7:0] word;
        hf_old = m_hf[d]; trip = 0; got = 0; b = 0; done = 0; word = '0;
        busy = m_vld[d] && !ready;
        if (strobe) begin
            if (m_run[d] > 0 && s == m_last[d]) m_run[d] = (m_run[d] < LIM) ? m_run[d] + 1 : LIM;
            else m_run[d] = 1;
            m_last[d] = s;
            trip = (m_run[d] == LIM);
            if (!hf_old && !trip) begin
                if (d == 0) begin
                    got = 1; b = s;
                end else if (!m_ph[d]) begin
                    m_ph[d] = 1; m_pa[d] = s;
                end else begin
                    m_ph[d] = 0;
                    if (m_pa[d] != s) begin got = 1; b = m_pa[d]; end
                end
            end
        end else if (clr) begin
            m_run[d] = 0;
        end
        if (trip) m_hf[d] = 1;
        else if (clr) m_hf[d] = 0;
        if (!en) begin
            m_nb[d] = 0; m_acc[d] = 0; m_ph[d] = 0;
        end else if (got) begin
            m_acc[d] = m_acc[d] * 2 + int'(b);
            m_nb[d]++;
            if (m_nb[d] == W) begin
                done = 1; word = 8'(m_acc[d]); m_nb[d] = 0; m_acc[d] = 0;
            end
        end
        if (done && !busy) begin
            m_dat[d] = word; m_vld[d] = 1;
        end else if (m_vld[d] && ready) begin
            m_vld[d] = 0;
        end
        if (done && busy) m_ov[d] = 1;
        else if (clr) m_ov[d] = 0;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_n = 0; m_roen = 0; m_fb = 2'b00;
            for (int d = 0; d < 2; d++) begin
                m_vld[d] = 0; m_dat[d] = '0; m_hf[d] = 0; m_ov[d] = 0; m_run[d] = 0;
                m_last[d] = 0; m_ph[d] = 0; m_pa[d] = 0; m_nb[d] = 0; m_acc[d] = 0;
            end
            m_h1 = 0; m_h2 = 0;
        end else begin
            m_s = m_h2;
            m_strobe = en && (m_n >= WARM + DIV) && ((m_n - WARM) % DIV == 0);
            model_dut(0, m_s, m_strobe);
            model_dut(1, m_s, m_strobe);
            m_n = en ? m_n + 1 : 0;
            m_roen = en;
            m_fb = fb_sel;
            m_h2 = m_h1;
            m_h1 = ro_in;
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus0.valid === 1'b1 && bus0.ready === 1'b1) cap0.push_back(bus0.data);
        if (bus1.valid === 1'b1 && bus1.ready === 1'b1) cap1.push_back(bus1.data);
        if (chk_on) begin
            chk("ro_enable0", 32'(bus0.ro_enable), 32'(m_roen));
            chk("fb_idx0", 32'(bus0.ro_fb_idx), 32'(m_fb));
            chk("valid0", 32'(bus0.valid), 32'(m_vld[0]));
            chk("data0", 32'(bus0.data), 32'(m_dat[0]));
            chk("health0", 32'(bus0.health_fail), 32'(m_hf[0]));
            chk("overrun0", 32'(bus0.overrun), 32'(m_ov[0]));
            chk("ro_enable1", 32'(bus1.ro_enable), 32'(m_roen));
            chk("fb_idx1", 32'(bus1.ro_fb_idx), 32'(m_fb));
            chk("valid1", 32'(bus1.valid), 32'(m_vld[1]));
            chk("data1", 32'(bus1.data), 32'(m_dat[1]));
            chk("health1", 32'(bus1.health_fail), 32'(m_hf[1]));
            chk("overrun1", 32'(bus1.overrun), 32'(m_ov[1]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    // Starts a run and holds bit k of pat (MSB first) around the k-th sample; returns just after the last sample.
    task automatic run_bits(input logic [63:0] pat, input int n);
        int e;
        e = 0;
        en = 1'b1;
        ro_in = pat[n-1];
        for (int k = 1; k < n; k++) begin
            while (e < 9 + 4 * k) begin @(posedge clk); e++; end
            #1;
            ro_in = pat[n-1-k];
        end
        while (e < 13 + 4 * (n - 1)) begin @(posedge clk); e++; end
        #1;
    endtask

    task automatic stop_run();
        en = 1'b0;
        idle(3);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ready = 1'b1; clr = 1'b0; ro_in = 1'b0; fb_sel = 2'b00;
        idle(3);
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst_valid", 32'(bus0.valid), 32'd0);
        chk("rst_data", 32'(bus0.data), 32'd0);
        chk("rst_ro_enable", 32'(bus0.ro_enable), 32'd0);
        chk("rst_flags", {30'd0, bus0.health_fail, bus0.overrun}, 32'd0);

        en = 1'b1;
        idle(1);
        chk("en_ro_enable", 32'(bus0.ro_enable), 32'd1);
        en = 1'b0;
        idle(2);

        // Raw word from 1,0,1,1,0,0,1,0.
        cap0.delete(); cap1.delete();
        run_bits(64'hB2, 8);
        stop_run();
        chk("t2_count", 32'(cap0.size()), 32'd1);
        chk("t2_word", qat0(0), 32'hB2);
        chk("t2_vn_count", 32'(cap1.size()), 32'd0);

        // Pairs 10,01,11,00,10,01,01,10,10,01.
        pulse_clr(); cap0.delete(); cap1.delete();
        run_bits(64'h9C969, 20);
        stop_run();
        chk("t3_vn_count", 32'(cap1.size()), 32'd1);
        chk("t3_vn_word", qat1(0), 32'hA6);
        chk("t3_raw_count", 32'(cap0.size()), 32'd2);
        chk("t3_raw_word0", qat0(0), 32'h9C);
        chk("t3_raw_word1", qat0(1), 32'h96);

        // Two words with the consumer stalled.
        pulse_clr(); cap0.delete(); cap1.delete();
        ready = 1'b0;
        run_bits(64'hC35A, 16);
        chk("t4_valid", 32'(bus0.valid), 32'd1);
        chk("t4_held", 32'(bus0.data), 32'hC3);
        chk("t4_overrun", 32'(bus0.overrun), 32'd1);
        stop_run();
        pulse_clr();
        chk("t4_overrun_clr", 32'(bus0.overrun), 32'd0);
        chk("t4_still_held", 32'(bus0.data), 32'hC3);
        ready = 1'b1;
        idle(3);
        chk("t4_drained", qat0(0), 32'hC3);
        chk("t4_drain_count", 32'(cap0.size()), 32'd1);

        // Stuck oscillator.
        pulse_clr(); cap0.delete(); cap1.delete();
        run_bits(64'hFFFF_FFFF, 32);
        chk("t5_health0", 32'(bus0.health_fail), 32'd1);
        chk("t5_health1", 32'(bus1.health_fail), 32'd1);
        stop_run();
        chk("t5_words", 32'(cap0.size()), 32'd3);
        chk("t5_word", qat0(2), 32'hFF);
        chk("t5_vn_words", 32'(cap1.size()), 32'd0);
        pulse_clr();
        chk("t5_health_clr", 32'(bus0.health_fail), 32'd0);

        // Abandoned partial word.
        pulse_clr(); cap0.delete(); cap1.delete();
        run_bits(64'h15, 5);
        stop_run();
        cap0.delete();
        run_bits(64'h3C, 8);
        stop_run();
        chk("t6_count", 32'(cap0.size()), 32'd1);
        chk("t6_word", qat0(0), 32'h3C);

        // Random traffic including a stuck stretch and a mid-run reset.
        pulse_clr();
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 2501) begin
                chk("mid_rst_valid", 32'(bus0.valid), 32'd0);
                chk("mid_rst_ro_enable", 32'(bus1.ro_enable), 32'd0);
                chk("mid_rst_flags", {30'd0, bus1.health_fail, bus1.overrun}, 32'd0);
            end
            if (en) en = ($urandom_range(0, 299) != 0);
            else    en = ($urandom_range(0, 19) == 0);
            ready  = ($urandom_range(0, 3) != 0);
            fb_sel = 2'($urandom_range(0, 3));
            clr    = (c < 1450 || c > 1800) && ($urandom_range(0, 99) == 0);
            if (c >= 1500 && c < 1700) ro_in = 1'b1;
            else                       ro_in = 1'($urandom_range(0, 1));
            rst_n = !(c == 2500);
        end
        clr = 1'b0;
        en = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
